apb_slave_ctrl: RTL and testbench

- Parametrised APB3/APB4 slave front-end for peripheral register blocks (timer, GPIO, etc.).
- Tracks the APB phases with an FSM and inserts a configurable number of wait states.
- Decodes the word address into per-register one-cycle write/read strobes and muxes register read data onto prdata.
- Flags out-of-range or misaligned accesses with pslverr.

---
 rtl/apb_slave_ctrl.sv | 160 ++++++++++++++++
 tb/tb_apb_slave_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_ctrl.sv
// APB3/APB4 slave front-end for a bank of word registers.
// Tracks IDLE/SETUP/ACCESS, inserts WAIT_CYC wait states, decodes the word
// address into one-cycle write/read strobes and muxes register read data.
// Out-of-range or misaligned accesses complete with pslverr. A sticky
// prot_err flags protocol violations seen on the bus.
module apb_slave_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 8,
    parameter int BASE_ADDR = 0,
    parameter int WAIT_CYC  = 1,
    parameter int STRB_EN   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    output logic                         pready,
    output logic                         pslverr,
    output logic [DATA_W-1:0]            prdata,
    output logic [NUM_REGS-1:0]          reg_wr_en,
    output logic [NUM_REGS-1:0]          reg_rd_en,
    output logic [DATA_W-1:0]            reg_wdata,
    output logic [DATA_W/8-1:0]          reg_wstrb,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_rdata,
    output logic                         prot_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] NREGS     = ADDR_W'(NUM_REGS);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              prot_err_reg, prot_err_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              write_reg, write_next;

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx;
    logic              hit;
    logic              acc_ok;
    logic [DATA_W-1:0] rd_slice [NUM_REGS];

    // Address decode; only meaningful while pready is high, when APB holds
    // paddr/pwrite stable.
    assign off    = paddr - BASE;
    assign idx    = off >> 2;
    assign hit    = (paddr >= BASE) && (paddr[1:0] == 2'b00) && (idx < NREGS);

    assign pready   = (state_reg == ST_ACCESS) && psel && penable && (cnt_reg == 4'd0);
    assign pslverr  = pready & ~hit;
    assign acc_ok   = pready & hit;
    assign prot_err = prot_err_reg;

    assign reg_wdata = pready ? pwdata : '0;

    generate
        if (STRB_EN != 0) begin : g_strb_pass
            assign reg_wstrb = pready ? pstrb : '0;
        end else begin : g_strb_ones
            assign reg_wstrb = pready ? {STRB_W{1'b1}} : '0;
        end
    endgenerate

    // Per-register strobes and read-data gating; at most one slice is nonzero.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign reg_wr_en[gi] = acc_ok &  pwrite & (idx == ADDR_W'(gi));
            assign reg_rd_en[gi] = acc_ok & ~pwrite & (idx == ADDR_W'(gi));
            assign rd_slice[gi]  = reg_rd_en[gi] ? reg_rdata[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    // OR the gated slices together to form prdata.
    always_comb begin
        prdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            prdata = prdata | rd_slice[i];
        end
    end

    // State, wait counter, captured address/direction and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            prot_err_reg <= 1'b0;
            addr_reg     <= '0;
            write_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            prot_err_reg <= prot_err_next;
            addr_reg     <= addr_next;
            write_reg    <= write_next;
        end
    end

    // Next-state logic, wait-state counting and protocol checking.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        prot_err_next = prot_err_reg;
        addr_next     = addr_reg;
        write_next    = write_reg;
        case (state_reg)
            ST_IDLE: begin
                if (psel && !penable) begin
                    state_next = ST_SETUP;
                end else if (psel && penable) begin
                    // Enable without a setup phase: ignored, but recorded.
                    prot_err_next = 1'b1;
                end
            end
            ST_SETUP: begin
                if (penable) begin
                    prot_err_next = 1'b1;
                end
                addr_next  = paddr;
                write_next = pwrite;
                cnt_next   = WAIT_INIT;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!psel) begin
                    // Master aborted before completion.
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    if ((paddr != addr_reg) || (pwrite != write_reg)) begin
                        prot_err_next = 1'b1;
                    end
                    if (pready) begin
                        // pready implies penable, so a same-cycle new setup
                        // (psel & ~penable) cannot coincide; return to IDLE.
                        state_next = ST_IDLE;
                    end else if (penable && (cnt_reg != 4'd0)) begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Bench for apb_slave_ctrl: four instances with different wait-state,
// base-address and strobe settings, each on its own APB bus. Table vectors,
// hand-written corner sequences and random transfers checked against a
// decode model built from the address rules.
module tb_apb_slave_ctrl;

    localparam int NDUT = 4;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int NR   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            psel_a    [NDUT];
    logic            penable_a [NDUT];
    logic            pwrite_a  [NDUT];
    logic [AW-1:0]   paddr_a   [NDUT];
    logic [DW-1:0]   pwdata_a  [NDUT];
    logic [3:0]      pstrb_a   [NDUT];
    logic            pready_a  [NDUT];
    logic            pslverr_a [NDUT];
    logic [DW-1:0]   prdata_a  [NDUT];
    logic [NR-1:0]   wr_en_a   [NDUT];
    logic [NR-1:0]   rd_en_a   [NDUT];
    logic [DW-1:0]   wdata_a   [NDUT];
    logic [3:0]      wstrb_a   [NDUT];
    logic [NR*DW-1:0] rdata_a  [NDUT];
    logic            prot_a    [NDUT];

    int wc_cfg   [NDUT] = '{1, 0, 3, 1};
    int base_cfg [NDUT] = '{0, 0, 0, 'h40};
    int strb_cfg [NDUT] = '{1, 1, 1, 0};

    logic [31:0] mem [NDUT][NR];

    int checks = 0;
    int errors = 0;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int WC = (gi == 1) ? 0 : (gi == 2) ? 3 : 1;
            localparam int BA = (gi == 3) ? 'h40 : 0;
            localparam int SE = (gi == 3) ? 0 : 1;
            apb_slave_ctrl #(
                .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR),
                .BASE_ADDR(BA), .WAIT_CYC(WC), .STRB_EN(SE)
            ) u_dut (
                .clk(clk), .rst_n(rst_n),
                .psel(psel_a[gi]), .penable(penable_a[gi]), .pwrite(pwrite_a[gi]),
                .paddr(paddr_a[gi]), .pwdata(pwdata_a[gi]), .pstrb(pstrb_a[gi]),
                .pready(pready_a[gi]), .pslverr(pslverr_a[gi]), .prdata(prdata_a[gi]),
                .reg_wr_en(wr_en_a[gi]), .reg_rd_en(rd_en_a[gi]),
                .reg_wdata(wdata_a[gi]), .reg_wstrb(wstrb_a[gi]),
                .reg_rdata(rdata_a[gi]), .prot_err(prot_a[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h expected=%0h", name, k, got, exp);
        end
    endtask

    // Decode model: expected error, one-hot strobe, byte enables and read data.
    task automatic model(input int k, input bit w, input int addr, input logic [3:0] strb,
                         output bit err, output logic [7:0] oh, output logic [3:0] ws,
                         output logic [31:0] rd);
        int off;
        off = addr - base_cfg[k];
        err = !((addr >= base_cfg[k]) && (addr % 4 == 0) && (off / 4 < NR));
        oh  = 8'h00;
        rd  = 32'h0;
        ws  = (strb_cfg[k] != 0) ? strb : 4'hF;
        if (!err) begin
            oh = 8'(1 << (off / 4));
            if (!w) rd = mem[k][off / 4];
        end
    endtask

    // One full transfer: two setup cycles, then enable until pready.
    task automatic xfer(input int k, input bit w, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        input bit exp_err, input logic [7:0] exp_oh,
                        input logic [3:0] exp_ws, input logic [31:0] exp_rd);
        int  n;
        bit  done;
        @(posedge clk); #1;
        psel_a[k] = 1'b1; penable_a[k] = 1'b0; pwrite_a[k] = w;
        paddr_a[k] = addr; pwdata_a[k] = wd; pstrb_a[k] = strb;
        @(posedge clk); #1;
        @(posedge clk); #1;
        penable_a[k] = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (pready_a[k]) begin
                done = 1'b1;
            end else begin
                chk("wait_strobes", k, {wr_en_a[k], rd_en_a[k]}, 0);
                chk("wait_pslverr", k, pslverr_a[k], 0);
            end
        end
        if (!done) begin
            chk("pready_timeout", k, 0, 1);
        end else begin
            chk("access_cycles", k, 64'(n), 64'(wc_cfg[k] + 1));
            chk("pslverr", k, pslverr_a[k], exp_err);
            chk("wr_en", k, wr_en_a[k], w ? exp_oh : 8'h00);
            chk("rd_en", k, rd_en_a[k], w ? 8'h00 : exp_oh);
            chk("prdata", k, prdata_a[k], exp_rd);
            if (w && !exp_err) begin
                chk("wdata", k, wdata_a[k], wd);
                chk("wstrb", k, wstrb_a[k], exp_ws);
            end
        end
        @(posedge clk); #1;
        psel_a[k] = 1'b0; penable_a[k] = 1'b0;
        @(negedge clk);
        chk("after_prdata", k, prdata_a[k], 0);
        chk("after_strobes", k, {wr_en_a[k], rd_en_a[k], pready_a[k]}, 0);
        $display("xfer dut%0d %s addr=%03h wdata=%08h strb=%h cycles=%0d rdata=%08h pslverr=%0b",
                 k, w ? "WR" : "RD", addr, wd, strb, n, prdata_a[k], exp_err);
    endtask

    typedef struct {
        int          k;
        bit          w;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        bit          err;
        logic [7:0]  oh;
        logic [3:0]  ws;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL global_timeout dut0 got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit          m_err;
        logic [7:0]  m_oh;
        logic [3:0]  m_ws;
        logic [31:0] m_rd;

        for (int k = 0; k < NDUT; k++) begin
            psel_a[k] = 0; penable_a[k] = 0; pwrite_a[k] = 0;
            paddr_a[k] = '0; pwdata_a[k] = '0; pstrb_a[k] = '0;
            for (int i = 0; i < NR; i++) mem[k][i] = $urandom;
        end
        mem[1][7] = 32'h12345678;
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < NR; i++) rdata_a[k][i*DW +: DW] = mem[k][i];

        tbl[0]  = '{0, 1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 1'b0, 8'h04, 4'hF};
        tbl[1]  = '{0, 1'b1, 12'h020, 32'h11111111, 4'hF, 1'b1, 8'h00, 4'hF};
        tbl[2]  = '{0, 1'b1, 12'h006, 32'h22222222, 4'hF, 1'b1, 8'h00, 4'hF};
        tbl[3]  = '{0, 1'b0, 12'h020, 32'h0,        4'h0, 1'b1, 8'h00, 4'h0};
        tbl[4]  = '{0, 1'b0, 12'h006, 32'h0,        4'h0, 1'b1, 8'h00, 4'h0};
        tbl[5]  = '{0, 1'b1, 12'h004, 32'hA5A5A5A5, 4'h3, 1'b0, 8'h02, 4'h3};
        tbl[6]  = '{0, 1'b1, 12'h01C, 32'h0BADF00D, 4'h0, 1'b0, 8'h80, 4'h0};
        tbl[7]  = '{1, 1'b0, 12'h01C, 32'h0,        4'h0, 1'b0, 8'h80, 4'h0};
        tbl[8]  = '{1, 1'b0, 12'h000, 32'h0,        4'h0, 1'b0, 8'h01, 4'h0};
        tbl[9]  = '{3, 1'b1, 12'h048, 32'hCAFEBABE, 4'h3, 1'b0, 8'h04, 4'hF};
        tbl[10] = '{3, 1'b0, 12'h03C, 32'h0,        4'h0, 1'b1, 8'h00, 4'h0};
        tbl[11] = '{3, 1'b0, 12'h05C, 32'h0,        4'h0, 1'b0, 8'h80, 4'h0};
        tbl[12] = '{3, 1'b1, 12'h060, 32'h33333333, 4'hF, 1'b1, 8'h00, 4'hF};
        tbl[13] = '{2, 1'b1, 12'h010, 32'h44444444, 4'hF, 1'b0, 8'h10, 4'hF};

        // Reset state
        #2;
        for (int k = 0; k < NDUT; k++) begin
            chk("reset_pready", k, pready_a[k], 0);
            chk("reset_pslverr", k, pslverr_a[k], 0);
            chk("reset_prdata", k, prdata_a[k], 0);
            chk("reset_strobes", k, {wr_en_a[k], rd_en_a[k]}, 0);
            chk("reset_prot_err", k, prot_a[k], 0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table vectors
        for (int t = 0; t < 14; t++) begin
            m_rd = 32'h0;
            if (!tbl[t].w && !tbl[t].err)
                for (int i = 0; i < NR; i++) if (tbl[t].oh[i]) m_rd = mem[tbl[t].k][i];
            xfer(tbl[t].k, tbl[t].w, tbl[t].addr, tbl[t].wd, tbl[t].strb,
                 tbl[t].err, tbl[t].oh, tbl[t].ws, m_rd);
        end

        // Abort on WAIT_CYC=3 after two access cycles
        @(posedge clk); #1;
        psel_a[2] = 1; penable_a[2] = 0; pwrite_a[2] = 1; paddr_a[2] = 12'h014;
        pwdata_a[2] = 32'h55AA55AA; pstrb_a[2] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        penable_a[2] = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_pready", 2, pready_a[2], 0);
            chk("abort_strobes", 2, {wr_en_a[2], rd_en_a[2]}, 0);
        end
        @(posedge clk); #1;
        psel_a[2] = 0; penable_a[2] = 0;
        @(negedge clk);
        chk("abort_idle_strobes", 2, {wr_en_a[2], rd_en_a[2], pready_a[2]}, 0);
        chk("abort_prot_err", 2, prot_a[2], 0);
        $display("abort dut2 addr=014 after 2 access cycles");
        xfer(2, 1'b1, 12'h014, 32'h55AA55AA, 4'hF, 1'b0, 8'h20, 4'hF, 32'h0);

        // Enable without setup: ignored, sticky prot_err
        @(posedge clk); #1;
        psel_a[0] = 1; penable_a[0] = 1; pwrite_a[0] = 1; paddr_a[0] = 12'h008;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("nosetup_pready", 0, pready_a[0], 0);
            chk("nosetup_strobes", 0, {wr_en_a[0], rd_en_a[0]}, 0);
        end
        chk("nosetup_prot_err", 0, prot_a[0], 1);
        @(posedge clk); #1;
        psel_a[0] = 0; penable_a[0] = 0;
        $display("protocol dut0 enable without setup");
        xfer(0, 1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, 8'h08, 4'h0, mem[0][3]);
        chk("prot_err_sticky", 0, prot_a[0], 1);

        // paddr change during ACCESS
        @(posedge clk); #1;
        psel_a[3] = 1; penable_a[3] = 0; pwrite_a[3] = 0; paddr_a[3] = 12'h048;
        @(posedge clk); #1;
        @(posedge clk); #1;
        penable_a[3] = 1;
        @(negedge clk);
        chk("addrchg_before", 3, prot_a[3], 0);
        @(posedge clk); #1;
        paddr_a[3] = 12'h04C;
        @(posedge clk); #1;
        psel_a[3] = 0; penable_a[3] = 0;
        @(negedge clk);
        chk("addrchg_prot_err", 3, prot_a[3], 1);
        $display("protocol dut3 paddr changed in access");

        // Reset during a wait state
        @(posedge clk); #1;
        psel_a[2] = 1; penable_a[2] = 0; pwrite_a[2] = 1; paddr_a[2] = 12'h00C;
        pwdata_a[2] = 32'h77777777; pstrb_a[2] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        penable_a[2] = 1;
        @(negedge clk);
        chk("rstmid_wait", 2, pready_a[2], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_pready", 2, {pready_a[2], pslverr_a[2]}, 0);
        chk("rstmid_strobes", 2, {wr_en_a[2], rd_en_a[2]}, 0);
        chk("rstmid_prdata", 2, prdata_a[2], 0);
        chk("rstmid_prot_err0", 0, prot_a[0], 0);
        chk("rstmid_prot_err3", 3, prot_a[3], 0);
        psel_a[2] = 0; penable_a[2] = 0;
        @(negedge clk);
        chk("rstmid_hold", 2, {wr_en_a[2], rd_en_a[2], pready_a[2]}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_release_prot", 0, prot_a[0], 0);
        $display("reset dut2 during wait state");
        xfer(2, 1'b1, 12'h00C, 32'h77777777, 4'hF, 1'b0, 8'h08, 4'hF, 32'h0);

        // Random transfers against the decode model
        for (int r = 0; r < 60; r++) begin
            int          k;
            bit          w;
            logic [11:0] addr;
            logic [31:0] wd;
            logic [3:0]  strb;
            k    = $urandom_range(0, NDUT - 1);
            w    = 1'($urandom_range(0, 1));
            addr = 12'($urandom_range(0, 'h7F));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            wd   = $urandom;
            strb = 4'($urandom_range(0, 15));
            model(k, w, int'(addr), strb, m_err, m_oh, m_ws, m_rd);
            xfer(k, w, addr, wd, strb, m_err, m_oh, m_ws, m_rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
